// File: rtl/kpscan.sv
// rtl/kpscan.sv - matrix keypad scanner with frame debounce and press/release strobes
// Optional: KPSCAN_LEGACY_MAP_EN selects the legacy 4x4 label map for key_code.
module kpscan #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4,
    parameter int CODE_W   = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1,
`ifdef KPSCAN_LEGACY_MAP_EN
    localparam int KW      = 4
`else
    localparam int KW      = CODE_W
`endif
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [ROWS-1:0] kpr,
    output logic [COLS-1:0] kpc,
    output logic [KW-1:0]   key_code,
    output logic            key_valid,
    output logic            key_strobe,
    output logic            key_release
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [3:0]    DEB        = 4'(DEBOUNCE);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PRESSED = 1'b1;

    generate
        if (ROWS < 1 || ROWS > 8 || COLS < 1 || COLS > 8 || SCAN_DIV < 4 ||
            DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_param
            $error("kpscan: parameter out of legal range");
        end
`ifdef KPSCAN_LEGACY_MAP_EN
        if (ROWS != 4 || COLS != 4) begin : g_bad_legacy
            $error("kpscan: legacy label map requires a 4x4 keypad");
        end
`endif
    endgenerate

    function automatic logic [COLS-1:0] col_drive(input logic [CW-1:0] c);
        logic [COLS-1:0] v;
        v = '1;
        v[COLS-1-int'(c)] = 1'b0;
        return v;
    endfunction

    function automatic logic [KW-1:0] code_of(input logic [RW-1:0] r, input logic [CW-1:0] c);
`ifdef KPSCAN_LEGACY_MAP_EN
        logic [3:0] idx;
        logic [3:0] lbl;
        idx = 4'(int'(r) * 4 + int'(c));
        case (idx)
            4'd0:  lbl = 4'd1;
            4'd1:  lbl = 4'd2;
            4'd2:  lbl = 4'd3;
            4'd3:  lbl = 4'd10;
            4'd4:  lbl = 4'd4;
            4'd5:  lbl = 4'd5;
            4'd6:  lbl = 4'd6;
            4'd7:  lbl = 4'd11;
            4'd8:  lbl = 4'd7;
            4'd9:  lbl = 4'd8;
            4'd10: lbl = 4'd9;
            4'd11: lbl = 4'd12;
            4'd12: lbl = 4'd14;
            4'd13: lbl = 4'd0;
            4'd14: lbl = 4'd15;
            default: lbl = 4'd13;
        endcase
        return lbl;
`else
        return KW'(int'(r) * COLS + int'(c));
`endif
    endfunction

    logic [ROWS-1:0] sync1, sync2;
    logic [DW-1:0]   dwell;
    logic [CW-1:0]   col;
    logic            acc_hit;
    logic [RW-1:0]   acc_r;
    logic [CW-1:0]   acc_c;
    logic            prev_hit;
    logic [RW-1:0]   prev_r;
    logic [CW-1:0]   prev_c;
    logic [3:0]      match;
    logic [0:0]      state;

    logic            col_hit;
    logic [RW-1:0]   col_hit_r;
    logic [CW-1:0]   col_next;
    logic            res_hit;
    logic [RW-1:0]   res_r;
    logic [CW-1:0]   res_c;
    logic            same;
    logic [3:0]      match_n;
    logic [KW-1:0]   res_code;

    // Descending scan so the lowest row index is the one left standing.
    always_comb begin
        col_hit   = 1'b0;
        col_hit_r = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!sync2[ROWS-1-r]) begin
                col_hit   = 1'b1;
                col_hit_r = RW'(r);
            end
        end
    end

    always_comb begin
        col_next = (col == COL_LAST) ? '0 : col + 1'b1;
        res_hit  = acc_hit | col_hit;
        res_r    = acc_hit ? acc_r : col_hit_r;
        res_c    = acc_hit ? acc_c : col;
        same     = (res_hit == prev_hit) && (!res_hit || (res_r == prev_r && res_c == prev_c));
        match_n  = !same ? 4'd1 : (match >= DEB) ? DEB : match + 4'd1;
        res_code = code_of(res_r, res_c);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1       <= '1;
            sync2       <= '1;
            dwell       <= '0;
            col         <= '0;
            kpc         <= col_drive('0);
            acc_hit     <= 1'b0;
            acc_r       <= '0;
            acc_c       <= '0;
            prev_hit    <= 1'b0;
            prev_r      <= '0;
            prev_c      <= '0;
            match       <= '0;
            state       <= IDLE;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_strobe  <= 1'b0;
            key_release <= 1'b0;
        end else begin
            sync1       <= kpr;
            sync2       <= sync1;
            key_strobe  <= 1'b0;
            key_release <= 1'b0;
            if (dwell == DWELL_LAST) begin
                dwell <= '0;
                col   <= col_next;
                kpc   <= col_drive(col_next);
                if (col == COL_LAST) begin
                    acc_hit  <= 1'b0;
                    prev_hit <= res_hit;
                    prev_r   <= res_r;
                    prev_c   <= res_c;
                    match    <= match_n;
                    if (match_n == DEB) begin
                        if (state == IDLE && res_hit) begin
                            state      <= PRESSED;
                            key_code   <= res_code;
                            key_valid  <= 1'b1;
                            key_strobe <= 1'b1;
                        end else if (state == PRESSED && !res_hit) begin
                            state       <= IDLE;
                            key_valid   <= 1'b0;
                            key_release <= 1'b1;
                        end else if (state == PRESSED && res_code != key_code) begin
                            key_code   <= res_code;
                            key_strobe <= 1'b1;
                        end
                    end
                end else if (!acc_hit && col_hit) begin
                    acc_hit <= 1'b1;
                    acc_r   <= col_hit_r;
                    acc_c   <= col;
                end
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_kpscan.sv
// tb/tb_kpscan.sv - directed self-checking bench for kpscan (4x4, SCAN_DIV=4, DEBOUNCE=2)
module tb_kpscan;

    localparam int FRAME = 16;
    localparam int LIMIT = 3 * FRAME + 3;

`ifdef KPSCAN_LEGACY_MAP_EN
    localparam logic [3:0] C_R1C2 = 4'd6;
    localparam logic [3:0] C_R2C1 = 4'd8;
    localparam logic [3:0] C_R0C3 = 4'd10;
    localparam logic [3:0] C_R3C0 = 4'd14;
    localparam logic [3:0] C_R3C2 = 4'd15;
`else
    localparam logic [3:0] C_R1C2 = 4'd6;
    localparam logic [3:0] C_R2C1 = 4'd9;
    localparam logic [3:0] C_R0C3 = 4'd3;
    localparam logic [3:0] C_R3C0 = 4'd12;
    localparam logic [3:0] C_R3C2 = 4'd14;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] kpr;
    logic [3:0] kpc;
    logic [3:0] key_code;
    logic       key_valid, key_strobe, key_release;
    logic [15:0] keys = '0;

    int n_tests = 0;
    int n_fail = 0;
    int n_strobe = 0;
    int n_release = 0;
    logic last_strobe = 1'b0;
    logic last_release = 1'b0;

    kpscan #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(2)) dut (
        .clk(clk), .reset_n(reset_n), .kpr(kpr), .kpc(kpc),
        .key_code(key_code), .key_valid(key_valid),
        .key_strobe(key_strobe), .key_release(key_release)
    );

    always #5 clk = ~clk;

    // Keypad model: a closed key at (r,c) pulls kpr[3-r] low while kpc[3-c] is low.
    always_comb begin
        kpr = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kpc[3-c]) kpr[3-r] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_strobe) n_strobe++;
        if (key_release) n_release++;
        if (key_strobe && key_release) begin
            n_fail++;
            $display("FAIL pulse_overlap: strobe=%0b release=%0b, required not both", key_strobe, key_release);
        end
        if ((key_strobe && last_strobe) || (key_release && last_release)) begin
            n_fail++;
            $display("FAIL pulse_width: strobe/release high two cycles, required one");
        end
        last_strobe  = key_strobe;
        last_release = key_release;
    end

    task automatic set_key(input int r, input int c, input logic v);
        keys[r*4+c] = v;
    endtask

    task automatic wait_pulse(input bit rel, input int max, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (rel ? key_release : key_strobe) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [3:0] exp_kpc;
        reset_n = 1'b0;
        keys = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({kpc, key_code, key_valid, key_strobe, key_release} !== {4'b0111, 4'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_state: kpc=%b code=%0d v/s/r=%b%b%b, required 0111 0 000",
                     kpc, key_code, key_valid, key_strobe, key_release);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            exp_kpc = ~(4'b1000 >> (((i + 1) / 4) % 4));
            n_tests++;
            if (kpc !== exp_kpc || key_valid !== 1'b0 || key_strobe !== 1'b0 || key_release !== 1'b0) begin
                n_fail++;
                $display("FAIL scan_seq[%0d]: kpc=%b v/s/r=%b%b%b, required %b 000",
                         i, kpc, key_valid, key_strobe, key_release, exp_kpc);
            end
        end
    endtask

    task automatic test_press_release;
        int s0, r0, cyc;
        s0 = n_strobe;
        r0 = n_release;
        set_key(1, 2, 1'b1);
        wait_pulse(1'b0, LIMIT, cyc);
        n_tests++;
        if (cyc < 0) begin
            n_fail++;
            $display("FAIL press_timeout: no key_strobe within %0d cycles", LIMIT);
        end
        repeat (FRAME) @(negedge clk);
        n_tests++;
        if (key_code !== C_R1C2 || key_valid !== 1'b1 || n_strobe - s0 !== 1 || n_release - r0 !== 0) begin
            n_fail++;
            $display("FAIL press: code=%0d valid=%b strobes=%0d releases=%0d, required %0d 1 1 0",
                     key_code, key_valid, n_strobe - s0, n_release - r0, C_R1C2);
        end
        set_key(1, 2, 1'b0);
        wait_pulse(1'b1, LIMIT, cyc);
        n_tests++;
        if (cyc < 0) begin
            n_fail++;
            $display("FAIL release_timeout: no key_release within %0d cycles", LIMIT);
        end
        repeat (FRAME) @(negedge clk);
        n_tests++;
        if (key_code !== C_R1C2 || key_valid !== 1'b0 || n_strobe - s0 !== 1 || n_release - r0 !== 1) begin
            n_fail++;
            $display("FAIL release: code=%0d valid=%b strobes=%0d releases=%0d, required %0d 0 1 1",
                     key_code, key_valid, n_strobe - s0, n_release - r0, C_R1C2);
        end
    endtask

    // Bursts of chatter each shorter than a frame, separated by long open gaps.
    task automatic test_bounce;
        int s0, r0;
        s0 = n_strobe;
        r0 = n_release;
        for (int b = 0; b < 4; b++) begin
            for (int t = 0; t < 4; t++) begin
                set_key(1, 2, (t % 2) == 0);
                repeat (3) @(negedge clk);
            end
            set_key(1, 2, 1'b0);
            repeat (40) @(negedge clk);
        end
        repeat (2 * FRAME) @(negedge clk);
        n_tests++;
        if (n_strobe - s0 !== 0 || n_release - r0 !== 0 || key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce: strobes=%0d releases=%0d valid=%b, required 0 0 0",
                     n_strobe - s0, n_release - r0, key_valid);
        end
    endtask

    task automatic test_simultaneous;
        int s0, r0, cyc;
        s0 = n_strobe;
        r0 = n_release;
        set_key(0, 3, 1'b1);
        set_key(2, 1, 1'b1);
        wait_pulse(1'b0, LIMIT, cyc);
        @(negedge clk);
        n_tests++;
        if (cyc < 0 || key_code !== C_R2C1 || key_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_press: cyc=%0d code=%0d valid=%b, required code %0d valid 1",
                     cyc, key_code, key_valid, C_R2C1);
        end
        set_key(2, 1, 1'b0);
        wait_pulse(1'b0, LIMIT, cyc);
        repeat (FRAME) @(negedge clk);
        n_tests++;
        if (cyc < 0 || key_code !== C_R0C3 || key_valid !== 1'b1 ||
            n_strobe - s0 !== 2 || n_release - r0 !== 0) begin
            n_fail++;
            $display("FAIL code_change: cyc=%0d code=%0d valid=%b strobes=%0d releases=%0d, required code %0d 1 2 0",
                     cyc, key_code, key_valid, n_strobe - s0, n_release - r0, C_R0C3);
        end
        set_key(0, 3, 1'b0);
        wait_pulse(1'b1, LIMIT, cyc);
        n_tests++;
        if (cyc < 0 || key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_release: cyc=%0d valid=%b, required pulse and valid 0", cyc, key_valid);
        end
        repeat (FRAME) @(negedge clk);
    endtask

    task automatic test_reset_mid_debounce;
        int cyc;
        set_key(1, 2, 1'b1);
        wait_pulse(1'b0, FRAME, cyc);
        n_tests++;
        if (cyc >= 0) begin
            n_fail++;
            $display("FAIL early_strobe: strobe after %0d cycles, required none within one frame", cyc);
        end
        #1 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({kpc, key_code, key_valid, key_strobe, key_release} !== {4'b0111, 4'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL mid_reset: kpc=%b code=%0d v/s/r=%b%b%b, required 0111 0 000",
                     kpc, key_code, key_valid, key_strobe, key_release);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_pulse(1'b0, 4 * FRAME, cyc);
        n_tests++;
        if (cyc < FRAME + 1 || cyc > LIMIT || key_code !== C_R1C2 || key_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL redebounce: latency=%0d code=%0d valid=%b, required latency %0d..%0d code %0d valid 1",
                     cyc, key_code, key_valid, FRAME + 1, LIMIT, C_R1C2);
        end
        set_key(1, 2, 1'b0);
        wait_pulse(1'b1, LIMIT, cyc);
        repeat (FRAME) @(negedge clk);
    endtask

    task automatic test_code_map;
        int cyc;
        set_key(3, 0, 1'b1);
        wait_pulse(1'b0, LIMIT, cyc);
        @(negedge clk);
        n_tests++;
        if (cyc < 0 || key_code !== C_R3C0) begin
            n_fail++;
            $display("FAIL map_r3c0: cyc=%0d code=%0d, required %0d", cyc, key_code, C_R3C0);
        end
        set_key(3, 0, 1'b0);
        set_key(3, 2, 1'b1);
        wait_pulse(1'b0, LIMIT, cyc);
        @(negedge clk);
        n_tests++;
        if (cyc < 0 || key_code !== C_R3C2 || key_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL map_r3c2: cyc=%0d code=%0d valid=%b, required %0d 1", cyc, key_code, key_valid, C_R3C2);
        end
        set_key(3, 2, 1'b0);
        wait_pulse(1'b1, LIMIT, cyc);
    endtask

    initial begin
        test_reset;
        test_press_release;
        test_bounce;
        test_simultaneous;
        test_reset_mid_debounce;
        test_code_map;
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
